// File: rtl/serial_pkg.sv
// Shared types and constants for the serial frame transmitter.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // Counter width that stays at least one bit even for a count of one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Valid/ready word handshake feeding the serial transmitter.
interface serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/serial_bit_timer.sv
// Bit-period timer: pulses bit_done in the last clock of every bit period.
module serial_bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int            CW   = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q;

  // Held at zero while cleared so a new frame starts on a full bit period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear || (count_q == LAST)) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

  assign bit_done = (count_q == LAST) && !clear;

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start bit, DATA_W bits LSB first, stop bit.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  serial_tx_if.slave   tx_if,
  output logic         tx_out,
  output logic         busy
);

  localparam int            BW       = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_e            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [BW-1:0]     bit_cnt_q;
  logic              tx_out_q;
  logic              tx_ready_q;
  logic              busy_q;
  logic              bit_done;

  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_q == IDLE),
    .bit_done (bit_done)
  );

  assign shift_d = shift_q >> 1;

  // Frame sequencer; line level and handshake outputs are set one edge ahead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      tx_out_q   <= LINE_IDLE;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tx_if.tx_valid && tx_ready_q) begin
            shift_q    <= tx_if.tx_data;
            state_q    <= START;
            tx_out_q   <= START_BIT;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            state_q  <= DATA;
            tx_out_q <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            shift_q <= shift_d;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              state_q   <= STOP;
              tx_out_q  <= LINE_IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
              tx_out_q  <= shift_d[0];
            end
          end
        end
        STOP: begin
          if (bit_done) begin
            state_q    <= IDLE;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          bit_cnt_q  <= '0;
          tx_out_q   <= LINE_IDLE;
          tx_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign tx_if.tx_ready = tx_ready_q;
  assign tx_out         = tx_out_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench: a cycle model pushes expected line bits on acceptance, monitors pop and compare.
module tb_serial_tx;

  localparam int N0 = (8 + 2) * 4;
  localparam int N1 = (4 + 2) * 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_out0, busy0, tx_out1, busy1;

  int checks = 0;
  int errors = 0;

  bit q0[$];
  bit q1[$];
  int m0 = 0, m1 = 0;
  int acc0 = 0, acc1 = 0;
  int run0 = 0, run1 = 0;
  bit e0, e1;

  serial_tx_if #(.DATA_W(8)) if0 ();
  serial_tx_if #(.DATA_W(4)) if1 ();

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut0 (
    .clk(clk), .rst(rst), .tx_if(if0.slave), .tx_out(tx_out0), .busy(busy0)
  );
  serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .tx_if(if1.slave), .tx_out(tx_out1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model for the 8-bit, 4-clock instance.
  always @(posedge clk) begin
    if (rst) begin
      q0.delete();
      m0 = 0;
    end else if (m0 == 0) begin
      if (if0.tx_valid) begin
        for (int k = 0; k < 4; k++) q0.push_back(1'b0);
        for (int i = 0; i < 8; i++)
          for (int k = 0; k < 4; k++) q0.push_back(if0.tx_data[i]);
        for (int k = 0; k < 4; k++) q0.push_back(1'b1);
        m0 = N0;
        acc0++;
      end
    end else begin
      m0--;
    end
  end

  // Reference model for the 4-bit, 1-clock instance.
  always @(posedge clk) begin
    if (rst) begin
      q1.delete();
      m1 = 0;
    end else if (m1 == 0) begin
      if (if1.tx_valid) begin
        q1.push_back(1'b0);
        for (int i = 0; i < 4; i++) q1.push_back(if1.tx_data[i]);
        q1.push_back(1'b1);
        m1 = N1;
        acc1++;
      end
    end else begin
      m1--;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q0.delete(); m0 = 0; run0 = 0;
      q1.delete(); m1 = 0; run1 = 0;
    end
    e0 = (q0.size() > 0) ? q0.pop_front() : 1'b1;
    chk("out0", {31'd0, tx_out0}, {31'd0, e0});
    chk("rdy0", {31'd0, if0.tx_ready}, {31'd0, (m0 == 0)});
    chk("busy0", {31'd0, busy0}, {31'd0, (m0 != 0)});
    if (busy0) run0++;
    else if (run0 != 0) begin chk("busylen0", run0, N0); run0 = 0; end
    e1 = (q1.size() > 0) ? q1.pop_front() : 1'b1;
    chk("out1", {31'd0, tx_out1}, {31'd0, e1});
    chk("rdy1", {31'd0, if1.tx_ready}, {31'd0, (m1 == 0)});
    chk("busy1", {31'd0, busy1}, {31'd0, (m1 != 0)});
    if (busy1) run1++;
    else if (run1 != 0) begin chk("busylen1", run1, N1); run1 = 0; end
  end

  task automatic wait_acc0(input int start);
    int n = 0;
    while (acc0 == start && n < 200) begin @(negedge clk); n++; end
    if (acc0 == start) chk("accept0_timeout", 32'd0, 32'd1);
  endtask

  task automatic send0(input logic [7:0] d);
    int start = acc0;
    #1; if0.tx_data = d; if0.tx_valid = 1'b1;
    wait_acc0(start);
    #1; if0.tx_valid = 1'b0;
  endtask

  task automatic send1(input logic [3:0] d);
    int start = acc1;
    int n = 0;
    #1; if1.tx_data = d; if1.tx_valid = 1'b1;
    while (acc1 == start && n < 200) begin @(negedge clk); n++; end
    if (acc1 == start) chk("accept1_timeout", 32'd0, 32'd1);
    #1; if1.tx_valid = 1'b0;
  endtask

  initial begin
    int start;
    if0.tx_data = 8'h00; if0.tx_valid = 1'b0;
    if1.tx_data = 4'h0;  if1.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // single frame
    send0(8'hA5);
    repeat (45) @(negedge clk);

    // back-to-back with valid held high
    start = acc0;
    #1; if0.tx_data = 8'h00; if0.tx_valid = 1'b1;
    wait_acc0(start);
    #1; if0.tx_data = 8'hFF;
    start = acc0;
    wait_acc0(start);
    #1; if0.tx_valid = 1'b0;
    repeat (45) @(negedge clk);

    // valid ignored while busy
    send0(8'h3C);
    repeat (5) @(negedge clk);
    #1; if0.tx_data = 8'hFF; if0.tx_valid = 1'b1;
    repeat (10) @(negedge clk);
    #1; if0.tx_valid = 1'b0;
    repeat (40) @(negedge clk);

    // data changes after handshake
    send0(8'h81);
    #1; if0.tx_data = 8'h7E;
    repeat (45) @(negedge clk);

    // reset in the middle of data bit 3
    send0(8'h55);
    repeat (17) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_out", {31'd0, tx_out0}, 32'd1);
    chk("rst_rdy", {31'd0, if0.tx_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    send0(8'h0F);
    repeat (45) @(negedge clk);

    // one clock per bit, four data bits
    send1(4'h9);
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
